// File: rtl/dpi_pkg.sv
// ---------------------------------------------------------------------------
// dpi_pkg
// Shared definitions for the DPI packet sequencer slice.
//   state_t           : sequencer FSM states
//   STREAM_SLOTS      : number of entries in the stream (flow) table
//   STREAM_ID_W       : width of a stream slot index
//   NUM_REGEX_DEFAULT : default number of downstream regex matchers
//   CHAR_W            : width of one character on the matcher bus
//   DRAIN_CNT_W       : width of the drain counter (DRAIN_CYCLES 1..7)
// ---------------------------------------------------------------------------
package dpi_pkg;

  localparam int STREAM_SLOTS      = 64;
  localparam int STREAM_ID_W       = 6;
  localparam int NUM_REGEX_DEFAULT = 8;
  localparam int CHAR_W            = 8;
  localparam int DRAIN_CNT_W       = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_LOAD,
    S_GAP,
    S_STREAM,
    S_DRAIN,
    S_EOP,
    S_RESULT
  } state_t;

endpackage

// File: rtl/dpi_stream_table.sv
// ---------------------------------------------------------------------------
// dpi_stream_table
// 64-entry flow-tag store. On lookup_en the tag is compared against every
// valid entry in parallel; the result is registered, so stream_id and
// new_stream are valid the cycle after lookup_en.
//   Hit  : stream_id = matching slot, new_stream = 0.
//   Miss : allocate the lowest-index free slot, or when the table is full
//          the round-robin victim (pointer then advances). new_stream = 1
//          and the tag is written into the chosen slot.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   lookup_en   : perform a lookup/allocate this cycle
//   lookup_tag  : flow tag to look up
//   stream_id   : registered slot index of the last lookup
//   new_stream  : registered "slot was freshly allocated" flag
// ---------------------------------------------------------------------------
module dpi_stream_table
  import dpi_pkg::*;
#(
  parameter int TAG_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   lookup_en,
  input  logic [TAG_W-1:0]       lookup_tag,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic                   new_stream
);

  logic [STREAM_SLOTS-1:0] valid_reg;
  logic [STREAM_SLOTS-1:0] hit_vec;
  logic [TAG_W-1:0]        tag_mem [STREAM_SLOTS];
  logic [STREAM_ID_W-1:0]  victim_reg;
  logic [STREAM_ID_W-1:0]  hit_idx;
  logic [STREAM_ID_W-1:0]  free_idx;
  logic [STREAM_ID_W-1:0]  alloc_idx;
  logic                    any_hit;
  logic                    any_free;

  // Parallel compare of all entries; invalid entries never hit, so the
  // un-reset tag storage contents are irrelevant.
  generate
    for (genvar gi = 0; gi < STREAM_SLOTS; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_reg[gi] && (tag_mem[gi] == lookup_tag);
    end
  endgenerate

  // Priority encoders: scanning downward leaves the lowest index set.
  always_comb begin
    hit_idx  = '0;
    free_idx = '0;
    for (int i = STREAM_SLOTS - 1; i >= 0; i--) begin
      if (hit_vec[i])    hit_idx  = STREAM_ID_W'(i);
      if (!valid_reg[i]) free_idx = STREAM_ID_W'(i);
    end
  end

  assign any_hit   = |hit_vec;
  assign any_free  = ~&valid_reg;
  assign alloc_idx = any_free ? free_idx : victim_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg  <= '0;
      victim_reg <= '0;
      stream_id  <= '0;
      new_stream <= 1'b0;
    end else if (lookup_en) begin
      if (any_hit) begin
        stream_id  <= hit_idx;
        new_stream <= 1'b0;
      end else begin
        stream_id            <= alloc_idx;
        new_stream           <= 1'b1;
        valid_reg[alloc_idx] <= 1'b1;
        if (!any_free) victim_reg <= victim_reg + STREAM_ID_W'(1);
      end
    end
  end

  // Tag storage carries no reset; validity is tracked by valid_reg.
  always_ff @(posedge clk) begin
    if (lookup_en && !any_hit) tag_mem[alloc_idx] <= lookup_tag;
  end

endmodule

// File: rtl/dpi_pkt_sequencer.sv
// ---------------------------------------------------------------------------
// dpi_pkt_sequencer
// Accepts a byte stream with sop/eop markers, maps each packet's flow tag to
// a stream slot, and sequences the shared character bus of NUM_REGEX regex
// matchers: state-restore strobe, gap cycle, characters, drain, eop, and
// finally a per-packet fired-flag result.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid/in_ready          : byte-stream handshake
//   in_data, in_sop, in_eop    : byte and first/last markers
//   in_flow_tag                : flow tag, sampled with the sop byte
//   cfg_enable                 : per-matcher enable mask
//   load_state, new_stream_id  : matcher state-restore strobe, fresh-stream flag
//   stream_id                  : stream slot index
//   char_in, char_in_vld       : character bus to matchers
//   eop                        : end-of-packet strobe
//   enable                     : enable mask held for the packet
//   fired_in                   : per-matcher fired flags
//   res_valid/res_stream_id/res_fired : per-packet result
// ---------------------------------------------------------------------------
module dpi_pkt_sequencer
  import dpi_pkg::*;
#(
  parameter int NUM_REGEX    = NUM_REGEX_DEFAULT,
  parameter int TAG_W        = 16,
  parameter int DRAIN_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CHAR_W-1:0]      in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  input  logic [TAG_W-1:0]       in_flow_tag,
  input  logic [NUM_REGEX-1:0]   cfg_enable,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic [CHAR_W-1:0]      char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  output logic [NUM_REGEX-1:0]   enable,
  input  logic [NUM_REGEX-1:0]   fired_in,
  output logic                   res_valid,
  output logic [STREAM_ID_W-1:0] res_stream_id,
  output logic [NUM_REGEX-1:0]   res_fired
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_INIT = DRAIN_CNT_W'(DRAIN_CYCLES);

  state_t                   state_reg;
  logic                     in_ready_reg;
  logic [CHAR_W-1:0]        sop_data_reg;
  logic                     sop_eop_reg;
  logic [TAG_W-1:0]         tag_reg;
  logic                     first_reg;
  logic [DRAIN_CNT_W-1:0]   drain_cnt_reg;
  logic                     load_state_reg;
  logic [CHAR_W-1:0]        char_in_reg;
  logic                     char_in_vld_reg;
  logic                     eop_reg;
  logic [NUM_REGEX-1:0]     enable_reg;
  logic                     res_valid_reg;
  logic [STREAM_ID_W-1:0]   res_stream_id_reg;
  logic [NUM_REGEX-1:0]     res_fired_reg;
  logic                     err_sop_reg;
  logic                     lookup_en;

  assign lookup_en = (state_reg == S_LOOKUP);

  dpi_stream_table #(
    .TAG_W (TAG_W)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_en  (lookup_en),
    .lookup_tag (tag_reg),
    .stream_id  (stream_id),
    .new_stream (new_stream_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= S_IDLE;
      in_ready_reg      <= 1'b0;
      sop_data_reg      <= '0;
      sop_eop_reg       <= 1'b0;
      tag_reg           <= '0;
      first_reg         <= 1'b0;
      drain_cnt_reg     <= '0;
      load_state_reg    <= 1'b0;
      char_in_reg       <= '0;
      char_in_vld_reg   <= 1'b0;
      eop_reg           <= 1'b0;
      enable_reg        <= '0;
      res_valid_reg     <= 1'b0;
      res_stream_id_reg <= '0;
      res_fired_reg     <= '0;
      err_sop_reg       <= 1'b0;
    end else begin
      // Single-cycle strobes default low.
      load_state_reg  <= 1'b0;
      char_in_vld_reg <= 1'b0;
      eop_reg         <= 1'b0;
      res_valid_reg   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          in_ready_reg <= 1'b1;
          // Bytes without sop are accepted and silently dropped.
          if (in_valid && in_ready_reg && in_sop) begin
            sop_data_reg <= in_data;
            sop_eop_reg  <= in_eop;
            tag_reg      <= in_flow_tag;
            in_ready_reg <= 1'b0;
            state_reg    <= S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          // Table result lands at this edge, together with the strobe.
          load_state_reg <= 1'b1;
          enable_reg     <= cfg_enable;
          state_reg      <= S_LOAD;
        end

        S_LOAD: begin
          state_reg <= S_GAP;
        end

        S_GAP: begin
          char_in_reg     <= sop_data_reg;
          char_in_vld_reg <= 1'b1;
          first_reg       <= 1'b1;
          state_reg       <= S_STREAM;
        end

        S_STREAM: begin
          if (first_reg) begin
            // sop byte is on the bus this cycle.
            first_reg <= 1'b0;
            if (sop_eop_reg) begin
              drain_cnt_reg <= DRAIN_INIT;
              state_reg     <= S_DRAIN;
            end else begin
              in_ready_reg <= 1'b1;
            end
          end else if (in_valid && in_ready_reg) begin
            char_in_reg     <= in_data;
            char_in_vld_reg <= 1'b1;
            if (in_sop) err_sop_reg <= 1'b1;
            if (in_eop) begin
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= DRAIN_INIT;
              state_reg     <= S_DRAIN;
            end
          end
        end

        S_DRAIN: begin
          // The final byte of a multi-byte packet is still on the bus in the
          // first DRAIN cycle; only bus-idle cycles count toward the drain.
          if (!char_in_vld_reg) begin
            if (drain_cnt_reg == DRAIN_CNT_W'(1)) begin
              eop_reg   <= 1'b1;
              state_reg <= S_EOP;
            end else begin
              drain_cnt_reg <= drain_cnt_reg - DRAIN_CNT_W'(1);
            end
          end
        end

        S_EOP: begin
          res_valid_reg     <= 1'b1;
          res_fired_reg     <= fired_in & enable_reg;
          res_stream_id_reg <= stream_id;
          state_reg         <= S_RESULT;
        end

        S_RESULT: begin
          in_ready_reg <= 1'b1;
          state_reg    <= S_IDLE;
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = in_ready_reg;
  assign load_state    = load_state_reg;
  assign char_in       = char_in_reg;
  assign char_in_vld   = char_in_vld_reg;
  assign eop           = eop_reg;
  assign enable        = enable_reg;
  assign res_valid     = res_valid_reg;
  assign res_stream_id = res_stream_id_reg;
  assign res_fired     = res_fired_reg;

endmodule

// File: tb/tb_dpi_pkt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dpi_pkt_sequencer
// Directed self-checking bench for dpi_pkt_sequencer.
// ---------------------------------------------------------------------------
module tb_dpi_pkt_sequencer;

  localparam int NR    = 8;
  localparam int TW    = 16;
  localparam int DRAIN = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = '0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic [TW-1:0] in_flow_tag = '0;
  logic [NR-1:0] cfg_enable = '0;
  logic          load_state;
  logic          new_stream_id;
  logic [5:0]    stream_id;
  logic [7:0]    char_in;
  logic          char_in_vld;
  logic          eop;
  logic [NR-1:0] enable;
  logic [NR-1:0] fired_in = '0;
  logic          res_valid;
  logic [5:0]    res_stream_id;
  logic [NR-1:0] res_fired;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         cyc_n = 0;
  logic [7:0] rx[$];
  int         last_char_cyc = 0;
  int         eop_cnt = 0;
  int         eop_cyc = 0;
  int         res_cnt = 0;
  int         res_cyc = 0;
  logic [5:0] res_id_seen = '0;
  logic [NR-1:0] res_f_seen = '0;
  logic [5:0] load_id = '0;
  logic [NR-1:0] load_en = '0;

  dpi_pkt_sequencer #(
    .NUM_REGEX    (NR),
    .TAG_W        (TW),
    .DRAIN_CYCLES (DRAIN)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_flow_tag   (in_flow_tag),
    .cfg_enable    (cfg_enable),
    .load_state    (load_state),
    .new_stream_id (new_stream_id),
    .stream_id     (stream_id),
    .char_in       (char_in),
    .char_in_vld   (char_in_vld),
    .eop           (eop),
    .enable        (enable),
    .fired_in      (fired_in),
    .res_valid     (res_valid),
    .res_stream_id (res_stream_id),
    .res_fired     (res_fired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle monitor: character scoreboard, strobe timing, stability.
  always @(negedge clk) begin
    cyc_n++;
    if (char_in_vld) begin
      rx.push_back(char_in);
      last_char_cyc = cyc_n;
    end
    if (load_state) begin
      load_id = stream_id;
      load_en = enable;
    end
    if (eop) begin
      eop_cnt++;
      eop_cyc = cyc_n;
      chk("eop_stream_id_stable", {26'd0, stream_id}, {26'd0, load_id});
      chk("eop_enable_stable", {24'd0, enable}, {24'd0, load_en});
    end
    if (res_valid) begin
      res_cnt++;
      res_cyc = cyc_n;
      res_id_seen = res_stream_id;
      res_f_seen = res_fired;
    end
    if (load_state || char_in_vld || eop)
      chk("strobe_exclusive", 32'(int'(load_state) + int'(char_in_vld) + int'(eop)), 32'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs_zero(input string ph);
    chk({ph, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({ph, "_load_state"}, {31'd0, load_state}, 32'd0);
    chk({ph, "_new_stream_id"}, {31'd0, new_stream_id}, 32'd0);
    chk({ph, "_stream_id"}, {26'd0, stream_id}, 32'd0);
    chk({ph, "_char_in"}, {24'd0, char_in}, 32'd0);
    chk({ph, "_char_in_vld"}, {31'd0, char_in_vld}, 32'd0);
    chk({ph, "_eop"}, {31'd0, eop}, 32'd0);
    chk({ph, "_enable"}, {24'd0, enable}, 32'd0);
    chk({ph, "_res_valid"}, {31'd0, res_valid}, 32'd0);
    chk({ph, "_res_stream_id"}, {26'd0, res_stream_id}, 32'd0);
    chk({ph, "_res_fired"}, {24'd0, res_fired}, 32'd0);
    chk({ph, "_err_sop"}, {31'd0, dut.err_sop_reg}, 32'd0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("rst_async");
    tick();
    tick();
    chk_outputs_zero("rst_held");
    rst_n = 1'b1;
    tick();
    chk("rst_release_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Drives one packet of len bytes (base, base+1, ...) and checks the full
  // matcher-bus timeline. sop_at marks a payload byte that also carries sop.
  task automatic run_pkt(input logic [15:0] tag, input int len, input logic [7:0] base,
                         input logic [5:0] exp_id, input logic exp_new,
                         input logic [NR-1:0] exp_fired, input bit toggle, input int sop_at);
    int guard;
    int i;
    int eop0;
    int res0;
    bit hold;
    bit drove;
    logic [7:0] dbyte;
    rx.delete();
    eop0 = eop_cnt;
    res0 = res_cnt;
    guard = 0;
    while (!in_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("wait_ready_in_time", {31'd0, in_ready}, 32'd1);

    in_valid = 1'b1;
    in_sop = 1'b1;
    in_eop = (len == 1);
    in_data = base;
    in_flow_tag = tag;
    tick();
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    chk("lookup_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("load_strobe", {31'd0, load_state}, 32'd1);
    chk("load_stream_id", {26'd0, stream_id}, {26'd0, exp_id});
    chk("load_new_stream_id", {31'd0, new_stream_id}, {31'd0, exp_new});
    chk("load_enable", {24'd0, enable}, {24'd0, cfg_enable});
    tick();
    chk("gap_no_char", {30'd0, char_in_vld, load_state}, 32'd0);
    tick();
    chk("sop_char_vld", {31'd0, char_in_vld}, 32'd1);
    chk("sop_char", {24'd0, char_in}, {24'd0, base});
    chk("sop_cycle_in_ready", {31'd0, in_ready}, 32'd0);

    i = 1;
    hold = 1'b0;
    guard = 0;
    while (i < len && guard < 200) begin
      drove = 1'b0;
      dbyte = 8'(base + i);
      if (in_ready && !(toggle && hold)) begin
        in_valid = 1'b1;
        in_data = dbyte;
        in_sop = (i == sop_at);
        in_eop = (i == len - 1);
        drove = 1'b1;
        hold = 1'b1;
        i++;
      end else begin
        in_valid = 1'b0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        hold = 1'b0;
      end
      tick();
      if (drove) begin
        chk("char_follows_vld", {31'd0, char_in_vld}, 32'd1);
        chk("char_follows_data", {24'd0, char_in}, {24'd0, dbyte});
      end else begin
        chk("char_idle_vld", {31'd0, char_in_vld}, 32'd0);
      end
      guard++;
    end
    in_valid = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    chk("payload_sent_in_time", i, len);

    guard = 0;
    while (res_cnt == res0 && guard < 40) begin
      tick();
      guard++;
    end
    chk("result_in_time", {31'd0, (res_cnt != res0)}, 32'd1);
    chk("rx_count", rx.size(), len);
    for (int k = 0; k < len && k < rx.size(); k++)
      chk("rx_data", {24'd0, rx[k]}, {24'd0, 8'(base + k)});
    chk("eop_count", eop_cnt - eop0, 32'd1);
    chk("res_count", res_cnt - res0, 32'd1);
    chk("drain_gap", eop_cyc - last_char_cyc, DRAIN + 1);
    chk("res_after_eop", res_cyc - eop_cyc, 32'd1);
    chk("res_stream_id", {26'd0, res_id_seen}, {26'd0, exp_id});
    chk("res_fired", {24'd0, res_f_seen}, {24'd0, exp_fired});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eop0;
    int res0;
    #2;
    do_reset();

    // First flow: fresh slot 0; 0xA5 & 0xFF = 0xA5.
    cfg_enable = 8'hA5;
    fired_in = 8'hFF;
    run_pkt(16'h1234, 3, 8'h10, 6'd0, 1'b1, 8'hA5, 1'b0, -1);
    // Same flow again: hit slot 0.
    cfg_enable = 8'h3C;
    fired_in = 8'hF0;
    run_pkt(16'h1234, 2, 8'h20, 6'd0, 1'b0, 8'h30, 1'b0, -1);
    // New flow with in_valid toggling: slot 1.
    cfg_enable = 8'hFF;
    fired_in = 8'h81;
    run_pkt(16'hBEEF, 5, 8'h30, 6'd1, 1'b1, 8'h81, 1'b1, -1);
    // 1-byte packet: slot 2, 0x05 & 0x0F = 0x05.
    cfg_enable = 8'h0F;
    fired_in = 8'h05;
    run_pkt(16'h0777, 1, 8'h47, 6'd2, 1'b1, 8'h05, 1'b0, -1);
    chk("err_sop_clear", {31'd0, dut.err_sop_reg}, 32'd0);
    // Stray sop inside payload is data but sets the sticky error.
    fired_in = 8'h00;
    run_pkt(16'h5555, 3, 8'h50, 6'd3, 1'b1, 8'h00, 1'b0, 1);
    chk("err_sop_set", {31'd0, dut.err_sop_reg}, 32'd1);

    // Reset in the middle of STREAM.
    eop0 = eop_cnt;
    res0 = res_cnt;
    cfg_enable = 8'hFF;
    in_valid = 1'b1;
    in_sop = 1'b1;
    in_data = 8'h60;
    in_flow_tag = 16'h6666;
    tick();
    in_valid = 1'b0;
    in_sop = 1'b0;
    tick();
    tick();
    tick();
    tick();
    in_valid = 1'b1;
    in_data = 8'h61;
    tick();
    in_valid = 1'b0;
    chk("mid_stream_char", {31'd0, char_in_vld}, 32'd1);
    #2;
    do_reset();
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("reset_no_eop", eop_cnt - eop0, 32'd0);
    chk("reset_no_res", res_cnt - res0, 32'd0);
    run_pkt(16'h6666, 2, 8'h70, 6'd0, 1'b1, 8'h00, 1'b0, -1);

    // Fill all 64 slots, then victim replacement.
    do_reset();
    cfg_enable = 8'h01;
    fired_in = 8'h01;
    for (int k = 0; k < 65; k++)
      run_pkt(16'(16'h1000 + k), 1, 8'(k), 6'(k), 1'b1, 8'h01, 1'b0, -1);
    run_pkt(16'h1002, 1, 8'hC2, 6'd2, 1'b0, 8'h01, 1'b0, -1);
    run_pkt(16'h2000, 1, 8'hD0, 6'd1, 1'b1, 8'h01, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
